fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the RV_PL pipeline: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, collects in-order responses and hands {pc, inst} to the decode stage, where the instruction word drives the immediate generator and control decoder. A small in-order fetch queue decouples memory latency from decode stalls. A redirect (branch/jump taken, flush) discards all queued and in-flight fetches and restarts at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- DEPTH, 2, fetch queue entries = maximum outstanding plus buffered fetches; legal 2..8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address, always word aligned
- imem_resp_valid  in  1  response word valid; responses in request order, earliest one cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts this cycle
- id_inst  out  32  instruction word; 32'h0000_0013 (addi x0,x0,0) when id_valid=0
- id_pc  out  32  address of id_inst; 0 when id_valid=0

## Operation
- State: pc register; circular queue of DEPTH entries {pc, inst, filled}; head/tail pointers and count; drop_cnt (0..DEPTH).
- Issue: imem_req_valid = ~redirect_valid & (count < DEPTH | pop). imem_req_addr = pc. On accept: allocate tail with {pc, filled=0}, pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
- Response: if drop_cnt > 0, discard word, drop_cnt -= 1. Otherwise write inst to oldest unfilled entry, set filled. Response with no unfilled entry and drop_cnt = 0 is a protocol error; ignore.
- Deliver: id_valid = head.filled & ~redirect_valid; pop when id_valid & id_ready; id_inst/id_pc from head entry.
- Redirect (highest priority): queue cleared (count=0, pointers reset); pc <= {redirect_pc[31:2], 2'b00}; drop_cnt <= drop_cnt + unfilled entries − (1 if imem_resp_valid this cycle); no request issued and no pop this cycle. Back-to-back redirects accumulate drop_cnt correctly; last redirect_pc wins.
- Requests during drop_cnt > 0 are allowed; their responses arrive after the dropped ones (in-order memory).
- Request held stable: once imem_req_valid=1 with ready=0, addr holds until accepted or a redirect occurs (redirect may withdraw a pending request).

## Timing
- Reset values: pc=RESET_PC, count=0, drop_cnt=0, imem_req_valid=0 while rst_n=0, id_valid=0, id_inst=32'h0000_0013, id_pc=0.
- First request: cycle after rst_n release, addr=RESET_PC.
- Fetch latency: request accepted cycle n, response cycle n+k (k≥1), id_valid cycle n+k+1.
- Throughput: with k=1, ready=1 always, DEPTH≥2: one instruction per cycle sustained.
- Redirect in cycle r: id_valid=0 and imem_req_valid=0 in r; request for redirect_pc in r+1; stale responses suppressed; first new instruction at id earliest r+3.
- Decode stall (id_ready=0): head held stable; issue stops once count=DEPTH; full queue plus pop in same cycle permits issue (no bubble).

## Test plan
- Reset release, 1-cycle memory, id_ready=1 -> requests 0x0,0x4,0x8,...; id_pc 0x0,0x4,0x8 on consecutive cycles from cycle 3; id_inst matches memory image.
- id_ready low 5 cycles with DEPTH=2 -> exactly 2 requests outstanding/buffered, imem_req_valid=0 after, head stays pc 0x8 stable; release -> no lost or duplicated pc.
- Redirect to 0x103 with 2 fetches in flight, 3-cycle memory -> next request addr 0x100, two stale responses dropped, first id_pc=0x100.
- Redirect in the same cycle as a response and an id handshake -> that response dropped, no pop, drop_cnt = unfilled−1, subsequent id_pc = redirect target.
- imem_req_ready random 50%, resp latency random 1-4 -> id stream strictly sequential pcs, addr stable while stalled.
- rst_n asserted mid-stream with fetches in flight -> all outputs to reset values immediately; post-reset first id_pc=RESET_PC, no stale word delivered.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches on a valid/ready channel and
// hands in-order {pc, inst} pairs to decode through a small circular fetch queue.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // a pending request keeps its address until accepted or withdrawn by a redirect.
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, filled_q, filled_d;
  logic [7:0]    drop_q, drop_d;
  logic          started_q;
  logic [31:0]   entry_pc_q   [DEPTH];
  logic [31:0]   entry_inst_q [DEPTH];

  logic          pop, accept, resp_fill, resp_drop;
  logic [CW-1:0] unfilled;
  logic [PW-1:0] fill_idx;
  logic [7:0]    drop_sum, drop_redir;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {{(CW+1-PW){1'b0}}, p} + {1'b0, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  // Entries fill in order from the head, so the oldest unfilled one sits at head + filled.
  always_comb begin
    unfilled       = count_q - filled_q;
    fill_idx       = ptr_add(head_q, filled_q);
    id_valid       = (filled_q != '0) & ~redirect_valid;
    pop            = id_valid & id_ready;
    imem_req_valid = started_q & ~redirect_valid & ((count_q < DEPTH_C) | pop);
    imem_req_addr  = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    resp_drop      = imem_resp_valid & (drop_q != '0);
    resp_fill      = imem_resp_valid & (drop_q == '0) & (unfilled != '0);
    drop_sum       = drop_q + {{(8-CW){1'b0}}, unfilled};
    drop_redir     = (imem_resp_valid && drop_sum != '0) ? drop_sum - 8'd1 : drop_sum;
    id_inst        = id_valid ? entry_inst_q[head_q] : NOP;
    id_pc          = id_valid ? entry_pc_q[head_q] : '0;
  end

  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    filled_d = filled_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      // Every fetch still owed by memory becomes a response to discard.
      pc_d     = {redirect_pc[31:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      filled_d = '0;
      drop_d   = drop_redir;
    end else begin
      if (accept) begin
        pc_d   = pc_q + 32'd4;
        tail_d = ptr_add(tail_q, ONE_C);
      end
      if (pop) head_d = ptr_add(head_q, ONE_C);
      if (resp_drop) drop_d = drop_q - 8'd1;
      count_d  = count_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};
      filled_d = filled_q + {{(CW-1){1'b0}}, resp_fill} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      filled_q  <= '0;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      filled_q  <= filled_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
    end
  end

  // Payload storage needs no reset: an entry is only read once its filled state says so.
  always_ff @(posedge clk) begin
    if (accept) entry_pc_q[tail_q] <= pc_q;
    if (resp_fill && !redirect_valid) entry_inst_q[fill_idx] <= imem_resp_data;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with configurable latency, directed vectors
// and sequences around stalls, redirects and reset, plus an expected-pc scoreboard.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Values applied at the next falling edge.
  logic        drv_rst_n = 1'b0;
  logic        drv_redir = 1'b0;
  logic [31:0] drv_redir_pc = '0;
  logic        drv_id_ready = 1'b1;
  bit          rand_ready = 0;
  int          lat_min = 1, lat_max = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  int          cyc = 0;
  int          n_deliv = 0;
  bit          sb_on = 0;
  logic [31:0] exp_q[$];
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;

  logic        s_req_valid, s_id_valid;
  logic [31:0] s_addr, s_id_pc, s_id_inst;

  typedef struct {
    logic        req_valid;
    logic [31:0] addr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step();
    int d;
    @(negedge clk);
    rst_n          = drv_rst_n;
    redirect_valid = drv_redir;
    redirect_pc    = drv_redir_pc;
    id_ready       = drv_id_ready;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!drv_rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
    end
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_inst   = id_inst;
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(d);
    end
    if (prev_stall && drv_rst_n && !drv_redir) begin
      check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    prev_stall = imem_req_valid & ~imem_req_ready & drv_rst_n;
    prev_addr  = imem_req_addr;
    if (id_valid && id_ready) begin
      n_deliv++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got pc %h expected none", id_pc);
        end else begin
          check("sb_id_pc", id_pc, exp_q.pop_front());
        end
        check("sb_id_inst", id_inst, mem_word(id_pc));
      end
    end
    if (drv_redir && sb_on) fill_exp({drv_redir_pc[31:2], 2'b00});
    cyc++;
  endtask

  task automatic reset_dut();
    drv_rst_n = 1'b0;
    drv_redir = 1'b0;
    drv_id_ready = 1'b1;
    sb_on = 0;
    exp_q.delete();
    step();
    step();
    drv_rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;

    // Reset values while rst_n is low.
    reset_dut();
    check("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("rst_id_valid", {31'b0, s_id_valid}, 32'd0);
    check("rst_id_inst", s_id_inst, 32'h0000_0013);
    check("rst_id_pc", s_id_pc, 32'd0);
    check("rst_addr", s_addr, 32'd0);

    // Streaming with 1-cycle memory: cycle-by-cycle vectors from reset release.
    tbl[0] = '{1'b0, 32'h0,  1'b0, 32'h0, 32'h0000_0013};
    tbl[1] = '{1'b1, 32'h0,  1'b0, 32'h0, 32'h0000_0013};
    tbl[2] = '{1'b1, 32'h4,  1'b0, 32'h0, 32'h0000_0013};
    tbl[3] = '{1'b1, 32'h8,  1'b1, 32'h0, mem_word(32'h0)};
    tbl[4] = '{1'b1, 32'hC,  1'b1, 32'h4, mem_word(32'h4)};
    tbl[5] = '{1'b1, 32'h10, 1'b1, 32'h8, mem_word(32'h8)};
    tbl[6] = '{1'b1, 32'h14, 1'b1, 32'hC, mem_word(32'hC)};
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t1_req_valid[%0d]", i), {31'b0, s_req_valid}, {31'b0, tbl[i].req_valid});
      check($sformatf("t1_addr[%0d]", i), s_addr, tbl[i].addr);
      check($sformatf("t1_id_valid[%0d]", i), {31'b0, s_id_valid}, {31'b0, tbl[i].id_valid});
      check($sformatf("t1_id_pc[%0d]", i), s_id_pc, tbl[i].id_pc);
      check($sformatf("t1_id_inst[%0d]", i), s_id_inst, tbl[i].id_inst);
    end
    fill_exp(32'h10);
    sb_on = 1;
    base = n_deliv;
    for (int i = 0; i < 20; i++) step();
    check("t1_throughput", 32'(n_deliv - base), 32'd20);

    // Decode stall for 5 cycles with the queue full.
    reset_dut();
    for (int i = 0; i < 5; i++) step();
    drv_id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_req_valid", {31'b0, s_req_valid}, 32'd0);
      check("t2_stall_id_valid", {31'b0, s_id_valid}, 32'd1);
      check("t2_stall_id_pc", s_id_pc, 32'h8);
    end
    drv_id_ready = 1'b1;
    fill_exp(32'h8);
    sb_on = 1;
    base = n_deliv;
    step();
    check("t2_release_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("t2_release_addr", s_addr, 32'h10);
    for (int i = 0; i < 10; i++) step();
    check("t2_deliv", 32'(n_deliv - base), 32'd11);

    // Redirect to an unaligned target with two fetches in flight, 3-cycle memory.
    reset_dut();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 3; i++) step();
    sb_on = 1;
    drv_redir = 1'b1;
    drv_redir_pc = 32'h103;
    base = n_deliv;
    step();
    check("t3_redir_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("t3_redir_id_valid", {31'b0, s_id_valid}, 32'd0);
    drv_redir = 1'b0;
    step();
    check("t3_new_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("t3_new_addr", s_addr, 32'h100);
    for (int i = 0; i < 12; i++) step();
    check("t3_progress", {31'b0, (n_deliv - base) >= 4}, 32'd1);

    // Redirect coinciding with a response and id_ready high.
    reset_dut();
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 5; i++) step();
    sb_on = 1;
    drv_redir = 1'b1;
    drv_redir_pc = 32'h200;
    base = n_deliv;
    step();
    check("t4_redir_id_valid", {31'b0, s_id_valid}, 32'd0);
    check("t4_redir_req_valid", {31'b0, s_req_valid}, 32'd0);
    drv_redir = 1'b0;
    step();
    check("t4_new_addr", s_addr, 32'h200);
    check("t4_new_req_valid", {31'b0, s_req_valid}, 32'd1);
    step();
    step();
    check("t4_first_id_valid", {31'b0, s_id_valid}, 32'd1);
    check("t4_first_id_pc", s_id_pc, 32'h200);
    for (int i = 0; i < 10; i++) step();
    check("t4_deliv", 32'(n_deliv - base), 32'd11);

    // Random ready, latency 1..4, random decode stalls and occasional redirects.
    reset_dut();
    rand_ready = 1;
    lat_min = 1;
    lat_max = 4;
    fill_exp(32'h0);
    sb_on = 1;
    base = n_deliv;
    for (int i = 0; i < 400; i++) begin
      drv_id_ready = ($urandom_range(0, 3) != 0);
      drv_redir = ($urandom_range(0, 39) == 0);
      drv_redir_pc = $urandom();
      step();
    end
    drv_redir = 1'b0;
    check("t5_progress", {31'b0, (n_deliv - base) > 50}, 32'd1);

    // Reset asserted mid-stream with fetches in flight.
    for (int i = 0; i < 6; i++) step();
    drv_rst_n = 1'b0;
    step();
    check("t6_rst_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("t6_rst_id_valid", {31'b0, s_id_valid}, 32'd0);
    check("t6_rst_id_inst", s_id_inst, 32'h0000_0013);
    check("t6_rst_id_pc", s_id_pc, 32'd0);
    check("t6_rst_addr", s_addr, 32'd0);
    drv_rst_n = 1'b1;
    fill_exp(32'h0);
    base = n_deliv;
    for (int i = 0; i < 40; i++) begin
      drv_id_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("t6_progress", {31'b0, (n_deliv - base) > 3}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
